// File: rtl/coin_input_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : coin_input_ctrl_if
// Brief    : Coin token handshake between the coin front-end and the vending
//            state machine (valid/ready, token value, occupancy, overflow).
// Revision : 1.0 - initial release
// ============================================================================
interface coin_input_ctrl_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             coin_valid;
  logic             pi_money;
  logic             coin_ready;
  logic [CNT_W-1:0] coin_cnt;
  logic             overflow;

  // Token producer side (the coin front-end)
  modport master (
    output coin_valid,
    output pi_money,
    output coin_cnt,
    output overflow,
    input  coin_ready
  );

  // Token consumer side (the vending state machine)
  modport slave (
    input  coin_valid,
    input  pi_money,
    input  coin_cnt,
    input  overflow,
    output coin_ready
  );
endinterface
`default_nettype wire

// File: rtl/coin_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : coin_input_ctrl
// Brief    : Synchronises and debounces the two active-low coin buttons,
//            turns each accepted press into a coin token and queues tokens in
//            a show-ahead FIFO presented with a valid/ready handshake.
//            Token encoding: 1 = 1 yuan, 0 = 0.5 yuan.
// Revision : 1.0 - initial release
// ============================================================================
module coin_input_ctrl #(
  parameter int CNT_MAX    = 999_999,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         key_half_in,
  input  wire logic         key_one_in,
  coin_input_ctrl_if.master coin
);

  localparam int CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int AW    = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_MAX);
  localparam logic [AW:0]      DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  // Key index 0 = 0.5-yuan button, 1 = 1-yuan button
  logic [1:0]       key_raw;
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       deb_q;
  logic [1:0]       deb_dly_q;
  logic [1:0]       press_q;
  logic [CNT_W-1:0] dcnt_q [2];

  assign key_raw = {key_one_in, key_half_in};

  // Two-flop synchroniser, debounce counter and falling-edge press detector per key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      deb_q     <= 2'b11;
      deb_dly_q <= 2'b11;
      press_q   <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        dcnt_q[k] <= '0;
      end
    end else begin
      sync1_q   <= key_raw;
      sync2_q   <= sync1_q;
      deb_dly_q <= deb_q;
      press_q   <= deb_dly_q & ~deb_q;
      for (int k = 0; k < 2; k++) begin
        if (sync2_q[k] == deb_q[k]) begin
          dcnt_q[k] <= '0;
        end else if (dcnt_q[k] == CNT_LAST) begin
          deb_q[k]  <= sync2_q[k];
          dcnt_q[k] <= '0;
        end else begin
          dcnt_q[k] <= dcnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Token arbitration: the 1-yuan token wins a simultaneous press, the half
  // token waits one cycle in the pending flag; extra half pulses merge into it.
  logic half_req;
  logic push;
  logic push_val;
  logic pend_q;
  logic pend_d;

  always_comb begin
    half_req = press_q[0] | pend_q;
    push     = press_q[1] | half_req;
    push_val = press_q[1];
    pend_d   = press_q[1] & half_req;
  end

  // Show-ahead FIFO
  logic [FIFO_DEPTH-1:0] mem_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           cnt_q;
  logic                  overflow_q;
  logic                  pop;
  logic                  full;
  logic                  wr_en;

  assign pop   = coin.coin_valid & coin.coin_ready;
  assign full  = (cnt_q == DEPTH_CNT);
  assign wr_en = push & (~full | pop);

  // Pointer, storage, occupancy and overflow update; a full FIFO still
  // accepts a token in a cycle where the head is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= 1'b0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      overflow_q <= push & full & ~pop;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_val;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Outputs derive from registers only, so coin_ready never reaches coin_valid
  assign coin.coin_valid = (cnt_q != '0);
  assign coin.pi_money   = coin.coin_valid & mem_q[rd_ptr_q];
  assign coin.coin_cnt   = cnt_q;
  assign coin.overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_input_ctrl
// Brief    : Self-checking bench for coin_input_ctrl with a behavioural
//            reference model (sample-window debounce, token queue).
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_input_ctrl;

  localparam int CM    = 9;
  localparam int DEPTH = 4;
  localparam int HL    = CM + 3;

  logic clk = 1'b0;
  logic rst;
  logic key_half_in;
  logic key_one_in;

  coin_input_ctrl_if #(.FIFO_DEPTH(DEPTH)) ifc ();

  coin_input_ctrl #(
    .CNT_MAX    (CM),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_half_in (key_half_in),
    .key_one_in  (key_one_in),
    .coin        (ifc)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int ovf_pulses = 0;

  // ---------------- reference model ----------------
  bit       hist [2][HL];   // hist[k][i] = raw sample taken i edges ago
  bit [1:0] m_deb;
  bit [1:0] fall_d1;
  bit [1:0] fall_d2;
  bit       m_pend;
  bit       m_ovf;
  bit       q [$];

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < HL; i++) hist[k][i] = 1'b1;
    m_deb   = 2'b11;
    fall_d1 = 2'b00;
    fall_d2 = 2'b00;
    m_pend  = 1'b0;
    m_ovf   = 1'b0;
    q.delete();
  endtask

  task automatic model_step();
    bit       raw [2];
    bit [1:0] fall_now;
    bit       one_ev;
    bit       half_req;
    bit       pop;
    bit       all_diff;
    if (rst) begin
      model_clear();
      return;
    end
    raw[0] = key_half_in;
    raw[1] = key_one_in;
    // a debounced press reaches the queue two edges after the level falls
    one_ev   = fall_d2[1];
    half_req = fall_d2[0] | m_pend;
    m_pend   = one_ev & half_req;
    pop      = (q.size() != 0) && ifc.coin_ready;
    if (pop) void'(q.pop_front());
    m_ovf = 1'b0;
    if (one_ev || half_req) begin
      if (q.size() < DEPTH) q.push_back(one_ev);
      else m_ovf = 1'b1;
    end
    // debounced level flips once the last CM+1 synchronised samples all disagree
    fall_now = 2'b00;
    for (int k = 0; k < 2; k++) begin
      for (int i = HL - 1; i > 0; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = raw[k];
      all_diff = 1'b1;
      for (int i = 2; i < HL; i++) if (hist[k][i] == m_deb[k]) all_diff = 1'b0;
      if (all_diff) begin
        m_deb[k]    = ~m_deb[k];
        fall_now[k] = ~m_deb[k];
      end
    end
    fall_d2 = fall_d1;
    fall_d1 = fall_now;
  endtask

  // ---------------- checking ----------------
  task automatic compare_all();
    bit       e_valid;
    bit       e_money;
    int       e_cnt;
    e_cnt   = q.size();
    e_valid = (e_cnt != 0);
    e_money = e_valid ? q[0] : 1'b0;
    vectors++;
    if (ifc.coin_valid !== e_valid || ifc.pi_money !== e_money ||
        int'(ifc.coin_cnt) != e_cnt || ifc.coin_cnt === 'x || ifc.overflow !== m_ovf) begin
      miscompares++;
      $display("FAIL model t=%0t: valid=%b/%b money=%b/%b cnt=%0d/%0d ovf=%b/%b (got/exp)",
               $time, ifc.coin_valid, e_valid, ifc.pi_money, e_money,
               ifc.coin_cnt, e_cnt, ifc.overflow, m_ovf);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (ifc.overflow === 1'b1) ovf_pulses++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_one();
    key_one_in = 1'b0;
    ticks(15);
    key_one_in = 1'b1;
    ticks(15);
  endtask

  // ticks until coin_valid first seen high, 0 if it never rises within budget
  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ifc.coin_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic drain(input int expect_n);
    int got;
    got = 0;
    ifc.coin_ready = 1'b1;
    for (int i = 0; i < 8 && ifc.coin_valid === 1'b1; i++) begin
      got++;
      tick();
    end
    ifc.coin_ready = 1'b0;
    chk("drain_count", got, expect_n);
  endtask

  initial begin
    int n;
    int n1;
    int n2;
    int last;
    int run_h;
    int run_o;

    rst = 1'b1;
    key_half_in = 1'b1;
    key_one_in  = 1'b1;
    ifc.coin_ready = 1'b0;
    model_clear();
    ticks(3);
    chk("reset_valid", int'(ifc.coin_valid), 0);
    chk("reset_cnt",   int'(ifc.coin_cnt),   0);
    chk("reset_money", int'(ifc.pi_money),   0);
    rst = 1'b0;
    ticks(2);

    // 1: held 1-yuan key, exact latency, no token on release
    key_one_in = 1'b0;
    wait_valid(n);
    chk("t1_latency", n, 14);
    chk("t1_money", int'(ifc.pi_money), 1);
    chk("t1_cnt",   int'(ifc.coin_cnt), 1);
    ticks(16);
    key_one_in = 1'b1;
    ticks(20);
    chk("t1_no_release_token", int'(ifc.coin_cnt), 1);
    drain(1);

    // 2: short glitch ignored
    key_half_in = 1'b0;
    ticks(8);
    key_half_in = 1'b1;
    ticks(20);
    chk("t2_cnt", int'(ifc.coin_cnt), 0);

    // 3: simultaneous press, half token one cycle later
    key_half_in = 1'b0;
    key_one_in  = 1'b0;
    n1 = 0;
    n2 = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (n1 == 0 && ifc.coin_cnt == 1) n1 = i;
      if (n2 == 0 && ifc.coin_cnt == 2) n2 = i;
    end
    chk("t3_first", n1, 14);
    chk("t3_second", n2, 15);
    key_half_in = 1'b1;
    key_one_in  = 1'b1;
    ticks(15);
    ifc.coin_ready = 1'b1;
    chk("t3_head0", int'(ifc.pi_money), 1);
    tick();
    chk("t3_head1", int'(ifc.pi_money), 0);
    chk("t3_valid1", int'(ifc.coin_valid), 1);
    tick();
    chk("t3_empty", int'(ifc.coin_valid), 0);
    ifc.coin_ready = 1'b0;

    // 4: five presses, saturate and overflow once, drain 1,1,1,1
    ovf_pulses = 0;
    for (int i = 0; i < 5; i++) press_one();
    chk("t4_cnt", int'(ifc.coin_cnt), 4);
    chk("t4_ovf", ovf_pulses, 1);
    ifc.coin_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_token", int'(ifc.pi_money), 1);
      tick();
    end
    ifc.coin_ready = 1'b0;
    chk("t4_empty", int'(ifc.coin_valid), 0);

    // 5: push and pop together while full
    for (int i = 0; i < 4; i++) press_one();
    ovf_pulses = 0;
    key_half_in = 1'b0;
    ticks(13);
    ifc.coin_ready = 1'b1;
    tick();
    ifc.coin_ready = 1'b0;
    chk("t5_cnt", int'(ifc.coin_cnt), 4);
    chk("t5_ovf", int'(ifc.overflow), 0);
    tick();
    key_half_in = 1'b1;
    ticks(15);
    chk("t5_no_ovf", ovf_pulses, 0);
    last = -1;
    ifc.coin_ready = 1'b1;
    for (int i = 0; i < 8 && ifc.coin_valid === 1'b1; i++) begin
      last = int'(ifc.pi_money);
      tick();
    end
    ifc.coin_ready = 1'b0;
    chk("t5_last", last, 0);

    // 6: reset mid-debounce with key held through reset release
    press_one();
    press_one();
    chk("t6_pre_cnt", int'(ifc.coin_cnt), 2);
    key_half_in = 1'b0;
    ticks(8);
    rst = 1'b1;
    model_clear();
    #1;
    chk("t6_rst_valid", int'(ifc.coin_valid), 0);
    chk("t6_rst_cnt",   int'(ifc.coin_cnt),   0);
    @(negedge clk);
    ticks(3);
    rst = 1'b0;
    wait_valid(n);
    chk("t6_latency", n, 14);
    chk("t6_money", int'(ifc.pi_money), 0);
    key_half_in = 1'b1;
    ticks(20);
    chk("t6_one_token", int'(ifc.coin_cnt), 1);
    drain(1);

    // random phase
    run_h = $urandom_range(1, 25);
    run_o = $urandom_range(1, 25);
    for (int i = 0; i < 3000; i++) begin
      if (--run_h == 0) begin
        key_half_in = ~key_half_in;
        run_h = $urandom_range(1, 25);
      end
      if (--run_o == 0) begin
        key_one_in = ~key_one_in;
        run_o = $urandom_range(1, 25);
      end
      ifc.coin_ready = ($urandom_range(0, 5) == 0);
      rst = (i >= 1500 && i < 1502);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
